// File: rtl/gtxe2_chnl_cpll_lockdet.sv
// CPLL lock detector: compares synchronized ref/fb rising-edge counts over fixed windows.
// Optional macro GTXE2_CPLL_LOCKDET_STICKY_LOST_EN makes the lost flags sticky until reset.
module gtxe2_chnl_cpll_lockdet #(
  parameter int CPLL_REFCLK_DIV = 1,
  parameter int WINDOW_LOG2     = 6,
  parameter int TOLERANCE       = 2,
  parameter int LOCK_WINDOWS    = 3
) (
  input  logic CPLLLOCKDETCLK,
  input  logic CPLLRESET,
  input  logic CPLLLOCKEN,
  input  logic CPLLPD,
  input  logic ref_tick,
  input  logic fb_tick,
  output logic CPLLLOCK,
  output logic CPLLREFCLKLOST,
  output logic CPLLFBCLKLOST
);

  localparam int W  = WINDOW_LOG2;
  localparam int DW = WINDOW_LOG2 + 2;

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_e;

  state_e         state_q, state_d;
  logic [2:0]     ref_sync_q, fb_sync_q;
  logic [W-1:0]   win_cnt_q, win_cnt_d;
  logic [W-1:0]   ref_cnt_q, ref_cnt_d;
  logic [W-1:0]   fb_cnt_q, fb_cnt_d;
  logic [3:0]     good_cnt_q, good_cnt_d;
  logic           armed_q, armed_d;
  logic           ref_lost_q, ref_lost_d;
  logic           fb_lost_q, fb_lost_d;

  logic           ref_rise, fb_rise;
  logic [W-1:0]   ref_tot, fb_tot;
  logic [DW-1:0]  fb_scaled;
  logic signed [DW-1:0] diff, diff_abs;
  logic           win_end, win_good, ref_none, fb_none;

  assign ref_rise = ref_sync_q[1] & ~ref_sync_q[2];
  assign fb_rise  = fb_sync_q[1] & ~fb_sync_q[2];

  always_ff @(posedge CPLLLOCKDETCLK or posedge CPLLRESET) begin
    if (CPLLRESET) begin
      state_q    <= IDLE;
      ref_sync_q <= '0;
      fb_sync_q  <= '0;
      win_cnt_q  <= '0;
      ref_cnt_q  <= '0;
      fb_cnt_q   <= '0;
      good_cnt_q <= '0;
      armed_q    <= 1'b0;
      ref_lost_q <= 1'b0;
      fb_lost_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_sync_q <= {ref_sync_q[1:0], ref_tick};
      fb_sync_q  <= {fb_sync_q[1:0], fb_tick};
      win_cnt_q  <= win_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      fb_cnt_q   <= fb_cnt_d;
      good_cnt_q <= good_cnt_d;
      armed_q    <= armed_d;
      ref_lost_q <= ref_lost_d;
      fb_lost_q  <= fb_lost_d;
    end
  end

  // A pulse landing in the window-end cycle is folded into the closing window's totals.
  always_comb begin
    ref_tot   = ref_cnt_q + W'(ref_rise);
    fb_tot    = fb_cnt_q + W'(fb_rise);
    fb_scaled = DW'(fb_tot) * DW'(CPLL_REFCLK_DIV);
    diff      = $signed(DW'(ref_tot)) - $signed(fb_scaled);
    diff_abs  = diff[DW-1] ? -diff : diff;
    ref_none  = (ref_tot == '0);
    fb_none   = (fb_tot == '0);
    win_good  = !ref_none && !fb_none && (diff_abs <= $signed(DW'(TOLERANCE)));
    win_end   = (state_q != IDLE) && armed_q && (win_cnt_q == '1);
  end

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    ref_cnt_d  = ref_cnt_q;
    fb_cnt_d   = fb_cnt_q;
    good_cnt_d = good_cnt_q;
    armed_d    = armed_q;
    ref_lost_d = ref_lost_q;
    fb_lost_d  = fb_lost_q;

    if (CPLLPD || !CPLLLOCKEN) begin
      state_d    = IDLE;
      win_cnt_d  = '0;
      ref_cnt_d  = '0;
      fb_cnt_d   = '0;
      good_cnt_d = '0;
      armed_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = MEASURE;
          win_cnt_d  = '0;
          ref_cnt_d  = '0;
          fb_cnt_d   = '0;
          good_cnt_d = '0;
          armed_d    = 1'b0;
        end
        default: begin
          // The MEASURE entry cycle only arms the window; counting starts next cycle.
          if (!armed_q) begin
            armed_d = 1'b1;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            if (win_end) begin
              ref_cnt_d = '0;
              fb_cnt_d  = '0;
`ifdef GTXE2_CPLL_LOCKDET_STICKY_LOST_EN
              ref_lost_d = ref_lost_q | ref_none;
              fb_lost_d  = fb_lost_q | (!ref_none && fb_none);
`else
              ref_lost_d = ref_none;
              fb_lost_d  = !ref_none && fb_none;
`endif
              if (win_good) begin
                if (state_q == MEASURE) begin
                  good_cnt_d = good_cnt_q + 4'd1;
                  if (good_cnt_q + 4'd1 == 4'(LOCK_WINDOWS)) begin
                    state_d = LOCKED;
                  end
                end
              end else begin
                good_cnt_d = '0;
                state_d    = MEASURE;
              end
            end else begin
              ref_cnt_d = ref_tot;
              fb_cnt_d  = fb_tot;
            end
          end
        end
      endcase
    end
  end

  assign CPLLLOCK       = (state_q == LOCKED);
  assign CPLLREFCLKLOST = ref_lost_q;
  assign CPLLFBCLKLOST  = fb_lost_q;

endmodule
